rect_label: RTL and testbench
=============================

RECT_LABEL -- requirements
Module: rect_label

Interface
REQ-001 SHALL have parameter IMG_W, default 40: pixels per row of the corroded binary image.
REQ-002 SHALL have parameter IMG_H, default 30: rows per frame.
REQ-003 SHALL have parameter CW, default 8: coordinate width; IMG_W-1 and IMG_H-1 fit in CW bits.
REQ-004 SHALL have parameter LBL_N, default 15: label slots; label width LW = clog2(LBL_N+1); label 0 = background.
REQ-005 SHALL have parameter SCALE_SH, default 2: left shift from corrosion grid to letter grid.
REQ-006 SHALL have parameters X_OFF, default 28, and Y_OFF, default 0: letter-grid offsets.
REQ-007 SHALL have parameter OW, default 8: output coordinate width; AW = clog2(IMG_W*IMG_H+1) is the area width.
REQ-008 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-009 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-010 i_sof  in  1  qualifies i_valid; marks pixel (0,0).
REQ-011 i_valid  in  1  pixel strobe; accepted only when o_pix_rdy=1.
REQ-012 i_wb  in  1  pixel value; 1 = white (object).
REQ-013 o_pix_rdy  out  1  block can accept a pixel this cycle.
REQ-014 i_smin_x, i_smin_y  in  CW each  minimum box width and height on the grid.
REQ-015 o_valid  out  1; i_ready  in  1: rectangle output handshake.
REQ-016 o_x1, o_y1, o_x2, o_y2  out  OW each  scaled box; o_area  out  AW  pixel count.
REQ-017 o_done  out  1  one-cycle pulse after the last record of a frame.
REQ-018 o_ovf  out  1  sticky per frame: label slots were exhausted.

Function
REQ-019 Raster order SHALL be used: x counts 0..IMG_W-1 then wraps with y+1; after (IMG_W-1, IMG_H-1) the block SHALL enter EMIT.
REQ-020 States SHALL be IDLE, CLASSIFY, WRITE, MERGE, RELABEL, EMIT, CLEAR; o_pix_rdy=1 only in IDLE.
REQ-021 Accept in IDLE at cycle t -> CLASSIFY at t+1 -> WRITE at t+2 -> IDLE at t+3; merge path: MERGE at t+2, RELABEL at t+3, IDLE at t+4.
REQ-022 CLASSIFY SHALL read up = line buffer entry IMG_W-1 (0 when y=0) and left = entry 0 (0 when x=0). A line buffer of IMG_W labels SHALL shift once per pixel.
REQ-023 Black pixel -> push 0.
REQ-024 White pixel, both neighbours 0 -> pop a free label L, set box (x,y,x,y), area 1, push L.
REQ-025 White pixel, exactly one neighbour nonzero, or up==left -> extend that label's min/max box, area+1, push it.
REQ-026 White pixel, up!=left, both nonzero -> MERGE: union left's box into up, area(up)=area(up)+area(left)+1, include (x,y), push up.
REQ-027 RELABEL SHALL replace every line-buffer entry equal to left with up, clear slot left, and push left onto the free stack.
REQ-028 Free stack empty on a new-label request -> pixel treated as black, o_ovf set until the next frame start.
REQ-029 i_sof accepted mid-frame -> CLEAR (1 cycle: all slots zeroed, free stack refilled 1..LBL_N, line buffer zeroed, o_ovf cleared); the sof pixel is then processed as (0,0).
REQ-030 EMIT SHALL scan slots 1..LBL_N in ascending order, skipping area=0 and boxes with x2-x1+1<i_smin_x or y2-y1+1<i_smin_y.
REQ-031 Emitted values: o_x1=(x1<<SCALE_SH)+X_OFF, o_y1=(y1<<SCALE_SH)+Y_OFF, o_x2=((x2+1)<<SCALE_SH)+X_OFF, o_y2=((y2+1)<<SCALE_SH)+Y_OFF, truncated to OW.
REQ-032 o_valid SHALL hold with stable data until i_ready=1; transfer on o_valid&i_ready; at most one slot examined per cycle.
REQ-033 After the last slot, o_done pulses for 1 cycle, then CLEAR, then IDLE (o_ovf retained until the next i_sof).
REQ-034 i_valid without i_sof while IDLE and awaiting a frame start SHALL be ignored.

Reset
REQ-035 sys_rst_n low SHALL asynchronously force: IDLE, awaiting frame start; o_pix_rdy=1; o_valid=0; o_done=0; o_ovf=0; all o_x*/o_y*/o_area=0; slots and line buffer 0; free stack 1..LBL_N (top=1).
REQ-036 Reset asserted mid-frame or mid-EMIT SHALL discard all records, with no o_done.

Verification (IMG_W=8, IMG_H=4, LBL_N=4, smin=1/1, defaults otherwise)
REQ-037 Single white pixel at (2,1) -> one record x1=36,y1=4,x2=40,y2=8, area=1, then o_done.
REQ-038 U shape: columns 1 and 3 white in rows 0-2, row 2 cols 1-3 white -> merge at (3,2); one record of box (1,0)-(3,2), area 7.
REQ-039 Five isolated pixels in row 0 at x=0,2,4,6 and (0,2) -> the fifth is dropped, o_ovf=1, four records.
REQ-040 i_smin_x=3 with boxes of width 2 and 3 -> only the width-3 box is emitted.
REQ-041 i_ready held low 5 cycles during EMIT -> o_valid and data stable, no record lost or duplicated.
REQ-042 i_sof mid-frame at pixel 13, then a full frame -> records reflect only the new frame; reset pulse in EMIT -> outputs return to reset values.

Source files
------------

// File: rtl/rect_label_if.sv
// Pixel-in / rectangle-out bus of the connected-component box labeller.
// Both handshakes: a beat transfers on the rising edge where the source's
// valid and the sink's ready are both 1; the source holds its data stable
// and keeps valid high until that edge.
interface rect_label_if #(
    parameter int CW = 8,
    parameter int OW = 8,
    parameter int AW = 11
);
    logic          i_sof;
    logic          i_valid;
    logic          i_wb;
    logic          o_pix_rdy;
    logic [CW-1:0] i_smin_x;
    logic [CW-1:0] i_smin_y;
    logic          o_valid;
    logic          i_ready;
    logic [OW-1:0] o_x1;
    logic [OW-1:0] o_y1;
    logic [OW-1:0] o_x2;
    logic [OW-1:0] o_y2;
    logic [AW-1:0] o_area;
    logic          o_done;
    logic          o_ovf;

    modport master (
        output i_sof, i_valid, i_wb, i_smin_x, i_smin_y, i_ready,
        input  o_pix_rdy, o_valid, o_x1, o_y1, o_x2, o_y2, o_area, o_done, o_ovf
    );

    modport slave (
        input  i_sof, i_valid, i_wb, i_smin_x, i_smin_y, i_ready,
        output o_pix_rdy, o_valid, o_x1, o_y1, o_x2, o_y2, o_area, o_done, o_ovf
    );
endinterface

// File: rtl/rect_label.sv
// Single-pass connected-component labeller: tracks bounding box and area per
// label over a raster frame, then emits scaled boxes that meet a minimum size.
module rect_label #(
    parameter int IMG_W    = 40,
    parameter int IMG_H    = 30,
    parameter int CW       = 8,
    parameter int LBL_N    = 15,
    parameter int SCALE_SH = 2,
    parameter int X_OFF    = 28,
    parameter int Y_OFF    = 0,
    parameter int OW       = 8
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    rect_label_if.slave  bus,
    output logic [2:0]   o_dbg_state
);
    localparam int LW = $clog2(LBL_N + 1);
    localparam int AW = $clog2(IMG_W * IMG_H + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLASSIFY, S_WRITE, S_MERGE, S_RELABEL, S_EMIT, S_CLEAR
    } state_t;

    localparam logic [1:0] ACT_BLACK = 2'd0;
    localparam logic [1:0] ACT_NEW   = 2'd1;
    localparam logic [1:0] ACT_EXT   = 2'd2;
    localparam logic [1:0] ACT_MERGE = 2'd3;

    state_t        state_q, state_d;
    logic [CW-1:0] x_q, y_q;
    logic          in_frame_q, sof_pend_q, wb_q;
    logic [1:0]    act_q;
    logic [LW-1:0] up_q, left_q, lbl_q;
    logic [LW-1:0] lb_q [IMG_W];
    logic [LW-1:0] fs_q [LBL_N];
    logic [LW-1:0] sp_q, idx_q;
    logic [CW-1:0] sx1_q [1:LBL_N];
    logic [CW-1:0] sy1_q [1:LBL_N];
    logic [CW-1:0] sx2_q [1:LBL_N];
    logic [CW-1:0] sy2_q [1:LBL_N];
    logic [AW-1:0] sa_q  [1:LBL_N];
    logic          ovf_q, done_q, ovalid_q;
    logic [OW-1:0] ox1_q, oy1_q, ox2_q, oy2_q;
    logic [AW-1:0] oarea_q;

    logic [LW-1:0] up_c, left_c, lbl_c, push_v_c;
    logic [1:0]    act_c;
    logic          ovf_set_c, accept_c, last_pix_c, last_idx_c, qual_c, finish_c;
    logic          push_en_c, adv_c;
    logic [CW:0]   w_c, h_c;

    function automatic logic [CW-1:0] cmin(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [CW-1:0] cmax(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [OW-1:0] scl(input logic [31:0] v, input int off);
        logic [31:0] t;
        t = (v << SCALE_SH) + 32'(off);
        return t[OW-1:0];
    endfunction

    assign up_c       = (y_q == '0) ? '0 : lb_q[IMG_W-1];
    assign left_c     = (x_q == '0) ? '0 : lb_q[0];
    assign accept_c   = bus.i_valid && (bus.i_sof || in_frame_q);
    assign last_pix_c = (x_q == CW'(IMG_W - 1)) && (y_q == CW'(IMG_H - 1));
    assign last_idx_c = (idx_q == LW'(LBL_N));
    assign w_c        = {1'b0, sx2_q[idx_q]} - {1'b0, sx1_q[idx_q]} + 1'b1;
    assign h_c        = {1'b0, sy2_q[idx_q]} - {1'b0, sy1_q[idx_q]} + 1'b1;
    assign qual_c     = (sa_q[idx_q] != '0) && (w_c >= {1'b0, bus.i_smin_x}) &&
                        (h_c >= {1'b0, bus.i_smin_y});
    assign finish_c   = last_idx_c && (ovalid_q ? bus.i_ready : !qual_c);
    assign push_en_c  = (state_q == S_WRITE) || (state_q == S_MERGE);
    assign push_v_c   = (state_q == S_MERGE) ? up_q : ((act_q == ACT_BLACK) ? '0 : lbl_q);
    assign adv_c      = (state_q == S_WRITE) || (state_q == S_RELABEL);

    // Neighbour classification; a new label with an empty free stack degrades to black.
    always_comb begin
        act_c     = ACT_BLACK;
        lbl_c     = '0;
        ovf_set_c = 1'b0;
        if (wb_q) begin
            if (up_c == '0 && left_c == '0) begin
                if (sp_q == '0) begin
                    ovf_set_c = 1'b1;
                end else begin
                    act_c = ACT_NEW;
                    lbl_c = fs_q[sp_q - 1'b1];
                end
            end else if (up_c == '0) begin
                act_c = ACT_EXT;
                lbl_c = left_c;
            end else if (left_c == '0 || up_c == left_c) begin
                act_c = ACT_EXT;
                lbl_c = up_c;
            end else begin
                act_c = ACT_MERGE;
                lbl_c = up_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept_c) state_d = (bus.i_sof && in_frame_q) ? S_CLEAR : S_CLASSIFY;
            S_CLASSIFY: state_d = (act_c == ACT_MERGE) ? S_MERGE : S_WRITE;
            S_WRITE:    state_d = last_pix_c ? S_EMIT : S_IDLE;
            S_MERGE:    state_d = S_RELABEL;
            S_RELABEL:  state_d = last_pix_c ? S_EMIT : S_IDLE;
            S_EMIT:     if (finish_c) state_d = S_CLEAR;
            S_CLEAR:    state_d = sof_pend_q ? S_CLASSIFY : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            in_frame_q <= 1'b0;
            sof_pend_q <= 1'b0;
            wb_q       <= 1'b0;
            act_q      <= ACT_BLACK;
            up_q       <= '0;
            left_q     <= '0;
            lbl_q      <= '0;
            sp_q       <= LW'(LBL_N);
            idx_q      <= LW'(1);
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            ovalid_q   <= 1'b0;
            ox1_q      <= '0;
            oy1_q      <= '0;
            ox2_q      <= '0;
            oy2_q      <= '0;
            oarea_q    <= '0;
            for (int i = 0; i < IMG_W; i++) lb_q[i] <= '0;
            for (int i = 0; i < LBL_N; i++) fs_q[i] <= LW'(LBL_N - i);
            for (int i = 1; i <= LBL_N; i++) begin
                sx1_q[i] <= '0;
                sy1_q[i] <= '0;
                sx2_q[i] <= '0;
                sy2_q[i] <= '0;
                sa_q[i]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (push_en_c) begin
                lb_q[0] <= push_v_c;
                for (int i = 1; i < IMG_W; i++) lb_q[i] <= lb_q[i-1];
            end
            if (adv_c) begin
                if (x_q == CW'(IMG_W - 1)) begin
                    x_q <= '0;
                    y_q <= last_pix_c ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
                if (last_pix_c) in_frame_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        wb_q <= bus.i_wb;
                        if (bus.i_sof) begin
                            x_q        <= '0;
                            y_q        <= '0;
                            in_frame_q <= 1'b1;
                            ovf_q      <= 1'b0;
                            sof_pend_q <= in_frame_q;
                        end
                    end
                end
                S_CLASSIFY: begin
                    act_q  <= act_c;
                    lbl_q  <= lbl_c;
                    up_q   <= up_c;
                    left_q <= left_c;
                    if (ovf_set_c) ovf_q <= 1'b1;
                end
                S_WRITE: begin
                    if (act_q == ACT_NEW) begin
                        sp_q         <= sp_q - 1'b1;
                        sx1_q[lbl_q] <= x_q;
                        sy1_q[lbl_q] <= y_q;
                        sx2_q[lbl_q] <= x_q;
                        sy2_q[lbl_q] <= y_q;
                        sa_q[lbl_q]  <= AW'(1);
                    end else if (act_q == ACT_EXT) begin
                        sx1_q[lbl_q] <= cmin(sx1_q[lbl_q], x_q);
                        sy1_q[lbl_q] <= cmin(sy1_q[lbl_q], y_q);
                        sx2_q[lbl_q] <= cmax(sx2_q[lbl_q], x_q);
                        sy2_q[lbl_q] <= cmax(sy2_q[lbl_q], y_q);
                        sa_q[lbl_q]  <= sa_q[lbl_q] + 1'b1;
                    end
                end
                S_MERGE: begin
                    sx1_q[up_q] <= cmin(cmin(sx1_q[up_q], sx1_q[left_q]), x_q);
                    sy1_q[up_q] <= cmin(cmin(sy1_q[up_q], sy1_q[left_q]), y_q);
                    sx2_q[up_q] <= cmax(cmax(sx2_q[up_q], sx2_q[left_q]), x_q);
                    sy2_q[up_q] <= cmax(cmax(sy2_q[up_q], sy2_q[left_q]), y_q);
                    sa_q[up_q]  <= sa_q[up_q] + sa_q[left_q] + 1'b1;
                end
                S_RELABEL: begin
                    for (int i = 0; i < IMG_W; i++)
                        if (lb_q[i] == left_q) lb_q[i] <= up_q;
                    sx1_q[left_q] <= '0;
                    sy1_q[left_q] <= '0;
                    sx2_q[left_q] <= '0;
                    sy2_q[left_q] <= '0;
                    sa_q[left_q]  <= '0;
                    fs_q[sp_q]    <= left_q;
                    sp_q          <= sp_q + 1'b1;
                end
                S_EMIT: begin
                    if (ovalid_q) begin
                        if (bus.i_ready) begin
                            ovalid_q <= 1'b0;
                            idx_q    <= idx_q + 1'b1;
                            done_q   <= last_idx_c;
                        end
                    end else if (qual_c) begin
                        ovalid_q <= 1'b1;
                        ox1_q    <= scl(32'(sx1_q[idx_q]), X_OFF);
                        oy1_q    <= scl(32'(sy1_q[idx_q]), Y_OFF);
                        ox2_q    <= scl(32'(sx2_q[idx_q]) + 32'd1, X_OFF);
                        oy2_q    <= scl(32'(sy2_q[idx_q]) + 32'd1, Y_OFF);
                        oarea_q  <= sa_q[idx_q];
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                        done_q <= last_idx_c;
                    end
                end
                S_CLEAR: begin
                    sp_q       <= LW'(LBL_N);
                    idx_q      <= LW'(1);
                    sof_pend_q <= 1'b0;
                    for (int i = 0; i < IMG_W; i++) lb_q[i] <= '0;
                    for (int i = 0; i < LBL_N; i++) fs_q[i] <= LW'(LBL_N - i);
                    for (int i = 1; i <= LBL_N; i++) begin
                        sx1_q[i] <= '0;
                        sy1_q[i] <= '0;
                        sx2_q[i] <= '0;
                        sy2_q[i] <= '0;
                        sa_q[i]  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_pix_rdy = (state_q == S_IDLE);
    assign bus.o_valid   = ovalid_q;
    assign bus.o_x1      = ox1_q;
    assign bus.o_y1      = oy1_q;
    assign bus.o_x2      = ox2_q;
    assign bus.o_y2      = oy2_q;
    assign bus.o_area    = oarea_q;
    assign bus.o_done    = done_q;
    assign bus.o_ovf     = ovf_q;
    assign o_dbg_state   = state_q;
endmodule

// File: tb/tb_rect_label.sv
// Directed bench for rect_label on an 8x4 frame with 4 label slots.
module tb_rect_label;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  rect_label_if #(.CW(8), .OW(8), .AW(6)) bus ();

  rect_label #(.IMG_W(8), .IMG_H(4), .LBL_N(4)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  logic [37:0] exp_q[$];
  logic [37:0] got_q[$];

  function automatic logic [37:0] rec(int x1, int y1, int x2, int y2, int a);
    return {8'(x1), 8'(y1), 8'(x2), 8'(y2), 6'(a)};
  endfunction

  // Transfer monitor: sampled between edges, a beat happens at the next rising edge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (bus.o_valid && bus.i_ready)
        got_q.push_back({bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2, bus.o_area});
      if (bus.o_done) done_cnt++;
    end
  end

  task automatic start_case();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_pix(input logic sof, input logic wb);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_pix_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total_cnt++;
      $display("FAIL pix_rdy_timeout: o_pix_rdy=0 after %0d cycles, required 1", n);
    end
    bus.i_valid = 1'b1;
    bus.i_sof   = sof;
    bus.i_wb    = wb;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_wb    = 1'b0;
  endtask

  task automatic drive_pixels(input logic [31:0] img, input int n);
    for (int k = 0; k < n; k++) send_pix(k == 0, img[k]);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (done_cnt > 0) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    total_cnt++;
    if (bus.o_pix_rdy !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_done !== 1'b0) begin
      $display("FAIL reset_ctrl: rdy/valid/done=%b%b%b, required 100", bus.o_pix_rdy, bus.o_valid, bus.o_done);
    end else pass_cnt++;
    total_cnt++;
    if (bus.o_ovf !== 1'b0) $display("FAIL reset_ovf: got %b, required 0", bus.o_ovf);
    else pass_cnt++;
    total_cnt++;
    if ({bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2, bus.o_area} !== 38'd0)
      $display("FAIL reset_data: got %h, required 0", {bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2, bus.o_area});
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d, required 0", dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_single();
    bit ok;
    start_case();
    exp_q.push_back(rec(36, 4, 40, 8, 1));
    drive_pixels(32'h1 << 10, 32);
    wait_done(ok);
    total_cnt++;
    if (!ok || done_cnt !== 1) $display("FAIL single_done: o_done pulses=%0d, required 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL single_count: got %0d records, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL single_rec%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_merge();
    bit ok;
    logic [31:0] img;
    start_case();
    img = (32'h1 << 1) | (32'h1 << 3) | (32'h1 << 9) | (32'h1 << 11) |
          (32'h1 << 17) | (32'h1 << 18) | (32'h1 << 19);
    exp_q.push_back(rec(32, 0, 44, 12, 7));
    drive_pixels(img, 32);
    wait_done(ok);
    total_cnt++;
    if (!ok || got_q.size() !== exp_q.size()) $display("FAIL merge_count: got %0d records, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL merge_rec%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.o_ovf !== 1'b0) $display("FAIL merge_ovf: got %b, required 0", bus.o_ovf);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit ok;
    logic [31:0] img;
    start_case();
    img = (32'h1 << 0) | (32'h1 << 2) | (32'h1 << 4) | (32'h1 << 6) | (32'h1 << 16);
    exp_q.push_back(rec(28, 0, 32, 4, 1));
    exp_q.push_back(rec(36, 0, 40, 4, 1));
    exp_q.push_back(rec(44, 0, 48, 4, 1));
    exp_q.push_back(rec(52, 0, 56, 4, 1));
    drive_pixels(img, 32);
    wait_done(ok);
    total_cnt++;
    if (!ok || got_q.size() !== exp_q.size()) $display("FAIL ovf_count: got %0d records, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL ovf_rec%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.o_ovf !== 1'b1) $display("FAIL ovf_flag: got %b, required 1", bus.o_ovf);
    else pass_cnt++;
  endtask

  task automatic test_min_width();
    bit ok;
    logic [31:0] img;
    start_case();
    bus.i_smin_x = 8'd3;
    img = (32'h1 << 0) | (32'h1 << 1) | (32'h1 << 19) | (32'h1 << 20) | (32'h1 << 21);
    exp_q.push_back(rec(40, 8, 52, 12, 3));
    drive_pixels(img, 32);
    total_cnt++;
    if (bus.o_ovf !== 1'b0) $display("FAIL minw_ovf_cleared: got %b, required 0", bus.o_ovf);
    else pass_cnt++;
    wait_done(ok);
    total_cnt++;
    if (!ok || got_q.size() !== exp_q.size()) $display("FAIL minw_count: got %0d records, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL minw_rec%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    bus.i_smin_x = 8'd1;
  endtask

  task automatic test_stall();
    bit ok;
    int n, bad;
    logic [37:0] held;
    start_case();
    exp_q.push_back(rec(28, 0, 32, 4, 1));
    exp_q.push_back(rec(44, 0, 48, 4, 1));
    exp_q.push_back(rec(36, 12, 40, 16, 1));
    bus.i_ready = 1'b0;
    drive_pixels((32'h1 << 0) | (32'h1 << 4) | (32'h1 << 26), 32);
    n = 0;
    while (!bus.o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    held = {bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2, bus.o_area};
    total_cnt++;
    if (bus.o_valid !== 1'b1 || held !== exp_q[0]) $display("FAIL stall_first: valid=%b data=%h, required 1 %h", bus.o_valid, held, exp_q[0]);
    else pass_cnt++;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b1 || {bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2, bus.o_area} !== held) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
    else pass_cnt++;
    bus.i_ready = 1'b1;
    wait_done(ok);
    total_cnt++;
    if (!ok || got_q.size() !== exp_q.size()) $display("FAIL stall_count: got %0d records, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL stall_rec%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sof_restart();
    bit ok;
    start_case();
    exp_q.push_back(rec(48, 12, 52, 16, 1));
    drive_pixels(32'hFFFF_FFFF, 13);
    drive_pixels(32'h1 << 29, 32);
    wait_done(ok);
    total_cnt++;
    if (!ok || done_cnt !== 1) $display("FAIL sof_done: o_done pulses=%0d, required 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL sof_count: got %0d records, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL sof_rec%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_in_emit();
    int n;
    start_case();
    bus.i_ready = 1'b0;
    drive_pixels(32'h1 << 10, 32);
    n = 0;
    while (!bus.o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (bus.o_valid !== 1'b1) $display("FAIL emit_reach: o_valid=%b, required 1", bus.o_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.o_valid !== 1'b0 || bus.o_pix_rdy !== 1'b1 ||
        {bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2, bus.o_area} !== 38'd0)
      $display("FAIL emit_reset: valid=%b rdy=%b data=%h, required 0 1 0", bus.o_valid, bus.o_pix_rdy,
               {bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2, bus.o_area});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (done_cnt !== 0 || got_q.size() !== 0) $display("FAIL emit_discard: done=%0d records=%0d, required 0 0", done_cnt, got_q.size());
    else pass_cnt++;
  endtask

  task automatic test_ignore_no_sof();
    bit ok;
    int bad;
    start_case();
    bad = 0;
    repeat (3) begin
      send_pix(1'b0, 1'b1);
      if (dbg_state !== 3'd0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL nosof_ignored: %0d pixels accepted, required 0", bad);
    else pass_cnt++;
    exp_q.push_back(rec(28, 0, 32, 4, 1));
    drive_pixels(32'h1, 32);
    wait_done(ok);
    total_cnt++;
    if (!ok || got_q.size() !== exp_q.size()) $display("FAIL nosof_count: got %0d records, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL nosof_rec%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    bus.i_sof    = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_wb     = 1'b0;
    bus.i_smin_x = 8'd1;
    bus.i_smin_y = 8'd1;
    bus.i_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_single();
    test_merge();
    test_overflow();
    test_min_width();
    test_stall();
    test_sof_restart();
    test_reset_in_emit();
    test_ignore_no_sof();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
